// File: rtl/irrigation_source_selector.sv
// Break-before-make selector for the A/B water-source mux: debounced request, minimum dwell, dead time, fault override.
// Optional switch counter enabled by defining SOURCE_SELECTOR_COUNT_EN.
module irrigation_source_selector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEAD_CYCLES     = 8,
    parameter int MIN_HOLD_CYCLES = 16
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       request_i,
    input  logic       force_b_i,
    output logic       selector_o,
    output logic       output_enable_o,
    output logic       switching_o,
    output logic [7:0] switch_count_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD_CYCLES);

    typedef enum logic [1:0] {
        ACTIVE_A  = 2'd0,
        ACTIVE_B  = 2'd1,
        DEAD_TO_A = 2'd2,
        DEAD_TO_B = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                req_db_q, req_db_d;
    logic                hold_met;
    logic                in_active_q;

    assign hold_met    = (hold_q == HOLD_MAX);
    assign in_active_q = (state_q == ACTIVE_A) || (state_q == ACTIVE_B);

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        req_db_d = req_db_q;
        db_cnt_d = '0;
        if (request_i != req_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                req_db_d = request_i;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q  <= DEAD_TO_B;
            dead_q   <= '0;
            hold_q   <= '0;
            db_cnt_q <= '0;
            req_db_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dead_q   <= dead_d;
            hold_q   <= hold_d;
            db_cnt_q <= db_cnt_d;
            req_db_q <= req_db_d;
        end
    end

    // force_b wins over the debounced request; a redirect restarts the full dead time.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACTIVE_A: begin
                if (force_b_i || (!req_db_q && hold_met)) state_d = DEAD_TO_B;
            end
            ACTIVE_B: begin
                if (req_db_q && hold_met && !force_b_i) state_d = DEAD_TO_A;
            end
            DEAD_TO_A: begin
                if (force_b_i)                state_d = DEAD_TO_B;
                else if (dead_q == DEAD_LAST) state_d = ACTIVE_A;
            end
            DEAD_TO_B: begin
                if (dead_q == DEAD_LAST) state_d = ACTIVE_B;
            end
            default: state_d = DEAD_TO_B;
        endcase

        dead_d = '0;
        hold_d = '0;
        if (state_d == state_q) begin
            if (in_active_q) hold_d = hold_met ? hold_q : hold_q + 1'b1;
            else             dead_d = dead_q + 1'b1;
        end
    end

    always_comb begin
        selector_o      = (state_q == ACTIVE_A) || (state_q == DEAD_TO_A);
        output_enable_o = in_active_q;
        switching_o     = !in_active_q;
    end

`ifdef SOURCE_SELECTOR_COUNT_EN
    logic [7:0] count_q;
    logic       start_switch;

    // Only ACTIVE->DEAD entries count; reset and redirects stay within DEAD states.
    assign start_switch = in_active_q && (state_d == DEAD_TO_A || state_d == DEAD_TO_B);

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (start_switch && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign switch_count_o = count_q;
`else
    assign switch_count_o = '0;
`endif

endmodule

// File: tb/tb_irrigation_source_selector.sv
// Directed bench for irrigation_source_selector; expected switch counts follow SOURCE_SELECTOR_COUNT_EN.
module tb_irrigation_source_selector;

`ifdef SOURCE_SELECTOR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       request = 1'b0;
    logic       force_b = 1'b0;
    logic       selector, output_enable, switching;
    logic [7:0] switch_count;
    int         n_cmp = 0;
    int         n_err = 0;

    irrigation_source_selector dut (
        .clock_i        (clock),
        .reset_n_i      (reset_n),
        .request_i      (request),
        .force_b_i      (force_b),
        .selector_o     (selector),
        .output_enable_o(output_enable),
        .switching_o    (switching),
        .switch_count_o (switch_count)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; request = 1'b0; force_b = 1'b0;
        step(2);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b001) begin
            n_err++; $display("FAIL reset_outs got %b want 001", {selector, output_enable, switching});
        end
        n_cmp++;
        if (switch_count !== 8'd0) begin
            n_err++; $display("FAIL reset_cnt got %0d want 0", switch_count);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({selector, output_enable, switching} !== 3'b001) begin
                n_err++; $display("FAIL reset_dead[%0d] got %b want 001", i, {selector, output_enable, switching});
            end
            step(1);
        end
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b010) begin
            n_err++; $display("FAIL reset_active got %b want 010", {selector, output_enable, switching});
        end
    endtask

    task automatic test_request_switch;
        step(16);
        request = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_cmp++;
            if ({selector, output_enable, switching} !== 3'b010) begin
                n_err++; $display("FAIL db_wait[%0d] got %b want 010", i, {selector, output_enable, switching});
            end
        end
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b101) begin
            n_err++; $display("FAIL to_a_dead got %b want 101", {selector, output_enable, switching});
        end
        n_cmp++;
        if (switch_count !== exp_cnt(1)) begin
            n_err++; $display("FAIL cnt_1 got %0d want %0d", switch_count, exp_cnt(1));
        end
        for (int i = 0; i < 7; i++) begin
            step(1);
            n_cmp++;
            if ({selector, output_enable, switching} !== 3'b101) begin
                n_err++; $display("FAIL dead_a[%0d] got %b want 101", i, {selector, output_enable, switching});
            end
        end
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b110) begin
            n_err++; $display("FAIL active_a got %b want 110", {selector, output_enable, switching});
        end
    endtask

    task automatic test_min_hold;
        request = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            n_cmp++;
            if ({selector, output_enable, switching} !== 3'b110) begin
                n_err++; $display("FAIL hold_wait[%0d] got %b want 110", i, {selector, output_enable, switching});
            end
        end
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b001) begin
            n_err++; $display("FAIL hold_leave got %b want 001", {selector, output_enable, switching});
        end
        n_cmp++;
        if (switch_count !== exp_cnt(2)) begin
            n_err++; $display("FAIL cnt_2 got %0d want %0d", switch_count, exp_cnt(2));
        end
        step(7);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b001) begin
            n_err++; $display("FAIL dead_b_end got %b want 001", {selector, output_enable, switching});
        end
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b010) begin
            n_err++; $display("FAIL active_b got %b want 010", {selector, output_enable, switching});
        end
    endtask

    task automatic test_glitch;
        request = 1'b1;
        for (int i = 0; i < 27; i++) begin
            if (i == 3) request = 1'b0;
            step(1);
            n_cmp++;
            if ({selector, output_enable, switching} !== 3'b010) begin
                n_err++; $display("FAIL glitch[%0d] got %b want 010", i, {selector, output_enable, switching});
            end
        end
    endtask

    task automatic test_force;
        request = 1'b1;
        step(13);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b110) begin
            n_err++; $display("FAIL force_pre got %b want 110", {selector, output_enable, switching});
        end
        step(2);
        force_b = 1'b1;
        step(1);
        force_b = 1'b0;
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b001) begin
            n_err++; $display("FAIL force_hit got %b want 001", {selector, output_enable, switching});
        end
        n_cmp++;
        if (switch_count !== exp_cnt(4)) begin
            n_err++; $display("FAIL cnt_4 got %0d want %0d", switch_count, exp_cnt(4));
        end
        step(8);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b010) begin
            n_err++; $display("FAIL force_done got %b want 010", {selector, output_enable, switching});
        end
        step(16);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b010) begin
            n_err++; $display("FAIL b_hold got %b want 010", {selector, output_enable, switching});
        end
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b101) begin
            n_err++; $display("FAIL to_a_again got %b want 101", {selector, output_enable, switching});
        end
        step(4);
        force_b = 1'b1;
        step(1);
        force_b = 1'b0;
        request = 1'b0;
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b001) begin
            n_err++; $display("FAIL redirect got %b want 001", {selector, output_enable, switching});
        end
        n_cmp++;
        if (switch_count !== exp_cnt(5)) begin
            n_err++; $display("FAIL cnt_redirect got %0d want %0d", switch_count, exp_cnt(5));
        end
        for (int i = 0; i < 7; i++) begin
            step(1);
            n_cmp++;
            if ({selector, output_enable, switching} !== 3'b001) begin
                n_err++; $display("FAIL redirect_dead[%0d] got %b want 001", i, {selector, output_enable, switching});
            end
        end
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b010) begin
            n_err++; $display("FAIL redirect_done got %b want 010", {selector, output_enable, switching});
        end
    endtask

    task automatic test_saturation;
        for (int it = 1; it <= 150; it++) begin
            request = 1'b1;
            step(30);
            force_b = 1'b1;
            step(1);
            force_b = 1'b0;
            step(8);
            n_cmp++;
            if ({selector, output_enable, switching, switch_count} !== {3'b010, exp_cnt(5 + 2 * it)}) begin
                n_err++;
                $display("FAIL sat[%0d] got %b/%0d want 010/%0d", it,
                         {selector, output_enable, switching}, switch_count, exp_cnt(5 + 2 * it));
            end
        end
    endtask

    task automatic test_reset_mid_switch;
        step(17);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b101) begin
            n_err++; $display("FAIL mid_pre got %b want 101", {selector, output_enable, switching});
        end
        step(3);
        reset_n = 1'b0;
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching, switch_count} !== {3'b001, 8'd0}) begin
            n_err++;
            $display("FAIL reset_mid got %b/%0d want 001/0", {selector, output_enable, switching}, switch_count);
        end
        reset_n = 1'b1;
        request = 1'b0;
        step(7);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b001) begin
            n_err++; $display("FAIL post_reset_dead got %b want 001", {selector, output_enable, switching});
        end
        step(1);
        n_cmp++;
        if ({selector, output_enable, switching} !== 3'b010) begin
            n_err++; $display("FAIL post_reset_active got %b want 010", {selector, output_enable, switching});
        end
    endtask

    initial begin
        test_reset;
        test_request_switch;
        test_min_hold;
        test_glitch;
        test_force;
        test_saturation;
        test_reset_mid_switch;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
